regfile_access_sequencer: RTL and testbench

//  Initiator for the register file's readsig/writesig/sr/dr/data_write/data_read port.

---
 rtl/regfile_access_sequencer.sv | 122 ++++++++++++
 tb/tb_regfile_access_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/regfile_access_sequencer.sv
// regfile_access_sequencer: sequences operand reads and (half-word RMW) writes over a single-ported register file
module regfile_access_sequencer #(
    parameter int DATA_W = 20,
    parameter int HALF_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_sa,
    input  logic [ADDR_W-1:0] req_sb,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_half,
    input  logic              req_hi,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              rsp_err,
    output logic              rf_readsig,
    output logic              rf_writesig,
    output logic [ADDR_W-1:0] rf_sr,
    output logic [ADDR_W-1:0] rf_dr,
    output logic [DATA_W-1:0] rf_data_write,
    input  logic [DATA_W-1:0] rf_data_read
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, RMW_RD, RMW_CAP, WR, RESP} state_t;
    state_t state, next;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] sa_q, sb_q, dst_q;
    logic [DATA_W-1:0] wd_q, a_q, b_q, ext, merged;
    logic              half_q, hi_q, err_q;
    always_comb begin
        ext = half_q ? DATA_W'(hi_q ? rf_data_read[DATA_W-1:HALF_W] : rf_data_read[HALF_W-1:0]) : rf_data_read;
        merged = hi_q ? {wd_q[HALF_W-1:0], rf_data_read[HALF_W-1:0]} : {rf_data_read[DATA_W-1:HALF_W], wd_q[HALF_W-1:0]};
    end
    always_ff @(posedge clk)
        if (!reset) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rf_readsig = 1'b0;
        rf_writesig = 1'b0;
        rf_sr = '0;
        rf_dr = '0;
        rf_data_write = '0;
        case (state)
            IDLE: begin
                req_ready = reset;
                if (req_valid && reset)
                    next = req_op == 2'b11 ? RESP : req_op == 2'b10 ? (req_half ? RMW_RD : WR) : RD_A;
            end
            RD_A: begin
                rf_readsig = 1'b1;
                rf_sr = sa_q;
                next = op_q == 2'b01 ? RD_B : CAP;
            end
            RD_B: begin
                rf_readsig = 1'b1;
                rf_sr = sb_q;
                next = CAP;
            end
            CAP: next = RESP;
            RMW_RD: begin
                rf_readsig = 1'b1;
                rf_sr = dst_q;
                next = RMW_CAP;
            end
            RMW_CAP: next = WR;
            WR: begin
                rf_writesig = 1'b1;
                rf_dr = dst_q;
                rf_data_write = wd_q;
                next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
        rsp_a = rsp_valid ? a_q : '0;
        rsp_b = rsp_valid ? b_q : '0;
        rsp_err = rsp_valid & err_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q <= '0;
            sa_q <= '0;
            sb_q <= '0;
            dst_q <= '0;
            wd_q <= '0;
            half_q <= 1'b0;
            hi_q <= 1'b0;
            err_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q <= req_op;
                sa_q <= req_sa;
                sb_q <= req_sb;
                dst_q <= req_dst;
                wd_q <= req_wdata;
                half_q <= req_half;
                hi_q <= req_hi;
                err_q <= req_op == 2'b11;
                a_q <= '0;
                b_q <= '0;
            end
            if (state == RD_B) a_q <= ext;
            if (state == CAP && op_q == 2'b01) b_q <= ext;
            if (state == CAP && op_q != 2'b01) a_q <= ext;
            if (state == RMW_CAP) wd_q <= merged;
        end
    end
endmodule

// File: tb/tb_regfile_access_sequencer.sv
// tb_regfile_access_sequencer: directed checks of the sequencer against a behavioural register file
module tb_regfile_access_sequencer;
    logic        clk = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_half = 1'b0, req_hi = 1'b0;
    logic [1:0]  req_op = '0;
    logic [2:0]  req_sa = '0, req_sb = '0, req_dst = '0;
    logic [19:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [19:0] rsp_a, rsp_b;
    logic        rf_readsig, rf_writesig;
    logic [2:0]  rf_sr, rf_dr;
    logic [19:0] rf_data_write, rf_data_read = '0;
    logic [19:0] mem [8];
    int          total = 0, bad = 0;
    int          rd_cnt = 0, wr_cnt = 0, clash = 0, leak = 0;
    logic [2:0]  last_dr = '0;
    logic [19:0] last_wd = '0;
    int          lat, rd0, wr0;
    logic [19:0] a, b;
    logic        err;
    regfile_access_sequencer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_sa(req_sa), .req_sb(req_sb), .req_dst(req_dst),
        .req_wdata(req_wdata), .req_half(req_half), .req_hi(req_hi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_err(rsp_err), .rf_readsig(rf_readsig), .rf_writesig(rf_writesig),
        .rf_sr(rf_sr), .rf_dr(rf_dr), .rf_data_write(rf_data_write), .rf_data_read(rf_data_read)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (rf_writesig) mem[rf_dr] <= rf_data_write;
        rf_data_read <= rf_readsig ? mem[rf_sr] : 20'h0;
    end
    always @(negedge clk) begin
        if (rf_readsig) rd_cnt++;
        if (rf_writesig) begin
            wr_cnt++;
            last_dr = rf_dr;
            last_wd = rf_data_write;
        end
        if (rf_readsig && rf_writesig) clash++;
        if ((!rf_readsig && rf_sr != 0) || (!rf_writesig && (rf_dr != 0 || rf_data_write != 0))) leak++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [1:0] op, input logic [2:0] sa, input logic [2:0] sb,
                        input logic [2:0] dst, input logic [19:0] wd, input logic half,
                        input logic hi, input int hold);
        logic [19:0] a0;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_op = op; req_sa = sa; req_sb = sb; req_dst = dst;
        req_wdata = wd; req_half = half; req_hi = hi; req_valid = 1'b1;
        chk("ready_idle", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (lat >= 20) begin
                chk("rsp_timeout", 0, 1);
                break;
            end
        end
        a = rsp_a; b = rsp_b; err = rsp_err; a0 = rsp_a;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 1);
            chk("hold_ready", {31'b0, req_ready}, 0);
            chk("hold_a", {12'b0, rsp_a}, {12'b0, a0});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask
    initial begin
        req_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", {31'b0, req_ready}, 0);
            chk("rst_strobe", {30'b0, rf_readsig, rf_writesig}, 0);
            chk("rst_rsp", {31'b0, rsp_valid}, 0);
        end
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 1);
        send(2'b10, 0, 0, 0, 20'h00055, 0, 0, 0);
        chk("w_lat", lat, 2);
        chk("w_wr", wr_cnt - wr0, 1);
        chk("w_rd", rd_cnt - rd0, 0);
        chk("w_dr", {29'b0, last_dr}, 0);
        chk("w_a", {12'b0, a}, 0);
        send(2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("r1_lat", lat, 3);
        chk("r1_a", {12'b0, a}, 32'h00055);
        chk("r1_b", {12'b0, b}, 0);
        chk("r1_rd", rd_cnt - rd0, 1);
        send(2'b10, 0, 0, 1, 20'hABCDE, 0, 0, 0);
        send(2'b10, 0, 0, 2, 20'h12345, 0, 0, 0);
        chk("w2_dr", {29'b0, last_dr}, 2);
        send(2'b01, 1, 2, 0, 0, 0, 0, 0);
        chk("r2_lat", lat, 4);
        chk("r2_a", {12'b0, a}, 32'hABCDE);
        chk("r2_b", {12'b0, b}, 32'h12345);
        chk("r2_rd", rd_cnt - rd0, 2);
        send(2'b01, 1, 1, 0, 0, 0, 0, 0);
        chk("r2same_a", {12'b0, a}, 32'hABCDE);
        chk("r2same_b", {12'b0, b}, 32'hABCDE);
        chk("r2same_rd", rd_cnt - rd0, 2);
        send(2'b10, 0, 0, 3, 20'hFFFFF, 0, 0, 0);
        send(2'b10, 0, 0, 3, 20'h00001, 1, 0, 0);
        chk("hw_lat", lat, 4);
        chk("hw_rd", rd_cnt - rd0, 1);
        chk("hw_wr", wr_cnt - wr0, 1);
        chk("hw_data", {12'b0, last_wd}, 32'hFFC01);
        send(2'b00, 3, 0, 0, 0, 1, 1, 0);
        chk("hr_hi", {12'b0, a}, 32'h003FF);
        send(2'b00, 3, 0, 0, 0, 1, 0, 0);
        chk("hr_lo", {12'b0, a}, 32'h00001);
        send(2'b01, 1, 2, 0, 0, 1, 1, 0);
        chk("hr2_a", {12'b0, a}, 32'h002AF);
        chk("hr2_b", {12'b0, b}, 32'h00048);
        send(2'b00, 1, 0, 0, 0, 0, 0, 5);
        chk("bp_a", {12'b0, a}, 32'hABCDE);
        send(2'b11, 0, 0, 0, 0, 0, 0, 0);
        chk("res_lat", lat, 1);
        chk("res_err", {31'b0, err}, 1);
        chk("res_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_op = 2'b10; req_dst = 3; req_wdata = 20'h002AA; req_half = 1'b1; req_hi = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {31'b0, req_ready}, 0);
        chk("mid_rst_rsp", {31'b0, rsp_valid}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle", {31'b0, req_ready}, 1);
        chk("mid_rst_nowr", wr_cnt - wr0, 0);
        send(2'b00, 3, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_keep", {12'b0, a}, 32'hFFC01);
        chk("strobe_clash", clash, 0);
        chk("strobe_leak", leak, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
